// File: rtl/ext_cap_list_walker.sv
// Walks the PCIe extended capability list from START_OFFSET looking for a requested capability ID.
// Optional build macro EXT_CAP_VERSION_CHECK_EN makes a version mismatch on the matching header an error.
module ext_cap_list_walker #(
  parameter logic [11:0] START_OFFSET     = 12'h100,
  parameter int          MAX_HOPS         = 64,
  parameter logic [3:0]  EXPECTED_VERSION = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] target_cap_id,
  output logic        cfg_rd_req,
  output logic [11:0] cfg_rd_addr,
  input  logic        cfg_rd_ack,
  input  logic [31:0] cfg_rd_data,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] cap_offset,
  output logic [3:0]  cap_version,
  output logic        error
);

  localparam int HOP_W = $clog2(MAX_HOPS + 1);

`ifdef EXT_CAP_VERSION_CHECK_EN
  localparam bit VER_CHECK = 1'b1;
`else
  localparam bit VER_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    DEC_EMPTY,
    DEC_MATCH,
    DEC_VER_BAD,
    DEC_END,
    DEC_BAD,
    DEC_LOOP,
    DEC_FOLLOW
  } dec_e;

  state_e               state_q, state_d;
  logic [15:0]          target_q, target_d;
  logic [11:0]          addr_q, addr_d;
  logic [HOP_W-1:0]     hops_q, hops_d;
  logic                 found_q, found_d;
  logic                 error_q, error_d;
  logic [11:0]          off_q, off_d;
  logic [3:0]           ver_q, ver_d;

  logic                 last_hop;
  dec_e                 dec;

  // Header classification in priority order; FOLLOW is the only outcome that keeps walking.
  function automatic dec_e decode_hdr(input logic [31:0] hdr,
                                      input logic [15:0] tgt,
                                      input logic        at_limit);
    logic [15:0] id;
    logic [3:0]  ver;
    logic [11:0] nxt;
    id  = hdr[15:0];
    ver = hdr[19:16];
    nxt = hdr[31:20];
    if (hdr == 32'h0000_0000 || hdr == 32'hFFFF_FFFF)
      return DEC_EMPTY;
    else if (id == tgt)
      return (VER_CHECK && ver != EXPECTED_VERSION) ? DEC_VER_BAD : DEC_MATCH;
    else if (nxt == 12'h000)
      return DEC_END;
    else if (nxt < 12'h100 || nxt[1:0] != 2'b00)
      return DEC_BAD;
    else if (at_limit)
      return DEC_LOOP;
    else
      return DEC_FOLLOW;
  endfunction

  assign last_hop = (hops_q + HOP_W'(1)) == HOP_W'(MAX_HOPS);
  assign dec      = decode_hdr(cfg_rd_data, target_q, last_hop);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  if (cfg_rd_ack && dec != DEC_FOLLOW) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Walk datapath and result registers
  always_comb begin
    target_d = target_q;
    addr_d   = addr_q;
    hops_d   = hops_q;
    found_d  = found_q;
    error_d  = error_q;
    off_d    = off_q;
    ver_d    = ver_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d = target_cap_id;
          addr_d   = START_OFFSET;
          hops_d   = '0;
          found_d  = 1'b0;
          error_d  = 1'b0;
          off_d    = 12'h000;
          ver_d    = 4'h0;
        end
      end
      S_REQ: begin
        if (cfg_rd_ack) begin
          hops_d = hops_q + HOP_W'(1);
          unique case (dec)
            DEC_MATCH: begin
              found_d = 1'b1;
              off_d   = addr_q;
              ver_d   = cfg_rd_data[19:16];
            end
            DEC_VER_BAD: begin
              error_d = 1'b1;
              off_d   = addr_q;
              ver_d   = cfg_rd_data[19:16];
            end
            DEC_BAD, DEC_LOOP: error_d = 1'b1;
            DEC_FOLLOW:        addr_d  = cfg_rd_data[31:20];
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= 16'h0000;
      addr_q   <= 12'h000;
      hops_q   <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
      off_q    <= 12'h000;
      ver_q    <= 4'h0;
    end else begin
      target_q <= target_d;
      addr_q   <= addr_d;
      hops_q   <= hops_d;
      found_q  <= found_d;
      error_q  <= error_d;
      off_q    <= off_d;
      ver_q    <= ver_d;
    end
  end

  // Output logic
  always_comb begin
    cfg_rd_req = (state_q == S_REQ);
    busy       = (state_q == S_REQ);
    done       = (state_q == S_DONE);
  end

  assign cfg_rd_addr = addr_q;
  assign found       = found_q;
  assign error       = error_q;
  assign cap_offset  = off_q;
  assign cap_version = ver_q;

endmodule

// File: tb/tb_ext_cap_list_walker.sv
// Directed bench for ext_cap_list_walker: a config-space responder with programmable wait states
// and a scoreboard of expected search results checked when done pulses.
module tb_ext_cap_list_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] target_cap_id;
  logic        cfg_rd_req;
  logic [11:0] cfg_rd_addr;
  logic        cfg_rd_ack;
  logic [31:0] cfg_rd_data;
  logic        busy, done, found, error;
  logic [11:0] cap_offset;
  logic [3:0]  cap_version;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];
  int          wait_cfg;
  int          wcnt;
  logic        force_ack;

  typedef struct {
    logic        found;
    logic        err;
    logic [11:0] off;
    logic [3:0]  ver;
    int          reads;
    int          cycles;
    logic [11:0] a1;
  } exp_t;

  exp_t sb[$];

  ext_cap_list_walker dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .target_cap_id (target_cap_id),
    .cfg_rd_req    (cfg_rd_req),
    .cfg_rd_addr   (cfg_rd_addr),
    .cfg_rd_ack    (cfg_rd_ack),
    .cfg_rd_data   (cfg_rd_data),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .cap_offset    (cap_offset),
    .cap_version   (cap_version),
    .error         (error)
  );

  always #5 clk = ~clk;

  // Config-space responder: ack/data change on the falling edge so the DUT sees them stable.
  always @(negedge clk) begin
    if (rst) begin
      cfg_rd_ack = 1'b0;
      wcnt = 0;
    end else if (force_ack) begin
      cfg_rd_ack  = 1'b1;
      cfg_rd_data = mem[cfg_rd_addr[11:2]];
    end else if (cfg_rd_req) begin
      if (wcnt < wait_cfg) begin
        cfg_rd_ack = 1'b0;
        wcnt++;
      end else begin
        cfg_rd_ack  = 1'b1;
        cfg_rd_data = mem[cfg_rd_addr[11:2]];
        wcnt = 0;
      end
    end else begin
      cfg_rd_ack = 1'b0;
      wcnt = 0;
    end
  end

  function automatic logic [31:0] hdr(input logic [15:0] id, input logic [3:0] ver,
                                      input logic [11:0] nxt);
    return {nxt, ver, id};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, cfg_rd_req}, 32'd0);
    chk({tag, "_addr"},  {20'd0, cfg_rd_addr}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_found"}, {31'd0, found}, 32'd0);
    chk({tag, "_off"},   {20'd0, cap_offset}, 32'd0);
    chk({tag, "_ver"},   {28'd0, cap_version}, 32'd0);
    chk({tag, "_err"},   {31'd0, error}, 32'd0);
  endtask

  // One search: pushes the expectation, drives start, tracks reads/cycles, pops on done.
  task automatic do_search(input string tag, input logic [15:0] tgt, input exp_t e,
                           input bit poke);
    int          cyc;
    int          nreads;
    bit          seen;
    logic [11:0] a0, a1;
    exp_t        x;
    a0 = 12'h0;
    a1 = 12'h0;
    @(negedge clk); #1;
    sb.push_back(e);
    start = 1'b1;
    target_cap_id = tgt;
    @(negedge clk); #1;
    start = 1'b0;
    cyc = 1;
    nreads = 0;
    seen = 1'b0;
    chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    chk({tag, "_req1"},  {31'd0, cfg_rd_req}, 32'd1);
    while (!seen && cyc < 400) begin
      if (poke && cyc == 1) begin
        start = 1'b1;
        target_cap_id = 16'h0001;
      end
      if (poke && cyc == 2) start = 1'b0;
      if (cfg_rd_req && cfg_rd_ack) begin
        if (nreads == 0) a0 = cfg_rd_addr;
        if (nreads == 1) a1 = cfg_rd_addr;
        nreads++;
      end
      if (done) seen = 1'b1;
      else begin
        @(negedge clk); #1;
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen && sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_found"},  {31'd0, found}, {31'd0, x.found});
      chk({tag, "_err"},    {31'd0, error}, {31'd0, x.err});
      chk({tag, "_off"},    {20'd0, cap_offset}, {20'd0, x.off});
      chk({tag, "_ver"},    {28'd0, cap_version}, {28'd0, x.ver});
      chk({tag, "_reads"},  nreads, x.reads);
      chk({tag, "_cycles"}, cyc, x.cycles);
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({tag, "_addr0"},  {20'd0, a0}, 32'h100);
      if (x.reads >= 2) chk({tag, "_addr1"}, {20'd0, a1}, {20'd0, x.a1});
      @(negedge clk); #1;
      chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
      chk({tag, "_hold_found"}, {31'd0, found}, {31'd0, x.found});
    end
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1;
    start = 1'b0;
    target_cap_id = 16'h0;
    wait_cfg = 0;
    wcnt = 0;
    force_ack = 1'b0;
    cfg_rd_ack = 1'b0;
    cfg_rd_data = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Two-entry list, target at the second header
    mem[12'h100 >> 2] = hdr(16'h0001, 4'h1, 12'h140);
    mem[12'h140 >> 2] = hdr(16'h0021, 4'h1, 12'h000);
    e = '{found: 1'b1, err: 1'b0, off: 12'h140, ver: 4'h1, reads: 2, cycles: 3, a1: 12'h140};
    do_search("find21", 16'h0021, e, 1'b0);

    e = '{found: 1'b0, err: 1'b0, off: 12'h000, ver: 4'h0, reads: 2, cycles: 3, a1: 12'h140};
    do_search("miss10", 16'h0010, e, 1'b0);

    // Wait states stretch the walk one cycle each
    wait_cfg = 2;
    e = '{found: 1'b1, err: 1'b0, off: 12'h140, ver: 4'h1, reads: 2, cycles: 7, a1: 12'h140};
    do_search("wait2", 16'h0021, e, 1'b0);

    // Start and a new target while busy must not disturb the walk
    wait_cfg = 1;
    e = '{found: 1'b1, err: 1'b0, off: 12'h140, ver: 4'h1, reads: 2, cycles: 5, a1: 12'h140};
    do_search("poke", 16'h0021, e, 1'b1);
    wait_cfg = 0;

    mem[12'h100 >> 2] = 32'hFFFF_FFFF;
    e = '{found: 1'b0, err: 1'b0, off: 12'h000, ver: 4'h0, reads: 1, cycles: 2, a1: 12'h000};
    do_search("absent", 16'h0021, e, 1'b0);

    mem[12'h100 >> 2] = hdr(16'h0001, 4'h1, 12'h0C2);
    e = '{found: 1'b0, err: 1'b1, off: 12'h000, ver: 4'h0, reads: 1, cycles: 2, a1: 12'h000};
    do_search("bad_next", 16'h0021, e, 1'b0);

    mem[12'h100 >> 2] = hdr(16'h0001, 4'h1, 12'h142);
    e = '{found: 1'b0, err: 1'b1, off: 12'h000, ver: 4'h0, reads: 1, cycles: 2, a1: 12'h000};
    do_search("misalign", 16'h0021, e, 1'b0);

    mem[12'h100 >> 2] = hdr(16'h0001, 4'h1, 12'h100);
    e = '{found: 1'b0, err: 1'b1, off: 12'h000, ver: 4'h0, reads: 64, cycles: 65, a1: 12'h100};
    do_search("selfloop", 16'h0021, e, 1'b0);

    mem[12'h100 >> 2] = hdr(16'h0001, 4'h1, 12'h140);
    mem[12'h140 >> 2] = hdr(16'h0021, 4'h2, 12'h000);
`ifdef EXT_CAP_VERSION_CHECK_EN
    e = '{found: 1'b0, err: 1'b1, off: 12'h140, ver: 4'h2, reads: 2, cycles: 3, a1: 12'h140};
`else
    e = '{found: 1'b1, err: 1'b0, off: 12'h140, ver: 4'h2, reads: 2, cycles: 3, a1: 12'h140};
`endif
    do_search("version", 16'h0021, e, 1'b0);

    // Reset during the second request with wait states pending
    mem[12'h140 >> 2] = hdr(16'h0021, 4'h1, 12'h000);
    wait_cfg = 3;
    @(negedge clk); #1;
    start = 1'b1;
    target_cap_id = 16'h0021;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_pre_addr", {20'd0, cfg_rd_addr}, 32'h140);
    chk("rst_pre_req",  {31'd0, cfg_rd_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("rst_async");
    @(negedge clk); #1;
    chk_idle_outputs("rst_next");
    rst = 1'b0;
    force_ack = 1'b1;
    @(negedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk); #1;
    chk_idle_outputs("late_ack");
    wait_cfg = 0;
    e = '{found: 1'b1, err: 1'b0, off: 12'h140, ver: 4'h1, reads: 2, cycles: 3, a1: 12'h140};
    do_search("after_rst", 16'h0021, e, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
